// File: rtl/seqdemux_if.sv
// Sample bus for seqdemux: four signed CV/audio inputs and four registered outputs.
interface seqdemux_if #(
    parameter int W = 16
);
    logic signed [W-1:0] sample_in0;
    logic signed [W-1:0] sample_in1;
    logic signed [W-1:0] sample_in2;
    logic signed [W-1:0] sample_in3;
    logic signed [W-1:0] sample_out0;
    logic signed [W-1:0] sample_out1;
    logic signed [W-1:0] sample_out2;
    logic signed [W-1:0] sample_out3;

    modport master (
        output sample_in0, sample_in1, sample_in2, sample_in3,
        input  sample_out0, sample_out1, sample_out2, sample_out3
    );

    modport slave (
        input  sample_in0, sample_in1, sample_in2, sample_in3,
        output sample_out0, sample_out1, sample_out2, sample_out3
    );
endinterface

// File: rtl/seqdemux.sv
// Sequential demultiplexer: a clock CV steps sample_in1 across outputs 1..3.
// Optional macro SEQDEMUX_ZERO_UNSELECTED_EN zeroes non-selected outputs instead of holding.
module seqdemux #(
    parameter int W         = 16,
    parameter int FP_OFFSET = 2
) (
    input logic        sample_clk,
    input logic        rst,
    seqdemux_if.slave  bus
);
    localparam logic signed [W-1:0] HI_TH   = W'(32'sd2000 <<< FP_OFFSET);
    localparam logic signed [W-1:0] LO_TH   = W'(32'sd500 <<< FP_OFFSET);
    localparam logic signed [W-1:0] GATE_HI = W'(32'sd5000 <<< FP_OFFSET);
    localparam logic signed [W-1:0] ZERO    = {W{1'b0}};

    typedef enum logic [1:0] {
        SEL_OUT1 = 2'd0,
        SEL_OUT2 = 2'd1,
        SEL_OUT3 = 2'd2,
        SEL_BAD  = 2'd3
    } sel_t;

    sel_t                sel_r;
    sel_t                sel_next_s;
    sel_t                step_s;
    logic                clk_st_r;
    logic                trig_st_r;
    logic                clk_st_next_s;
    logic                trig_st_next_s;
    logic                clk_edge_s;
    logic                trig_edge_s;
    logic                reverse_s;
    logic signed [W-1:0] out0_r;
    logic signed [W-1:0] out1_r;
    logic signed [W-1:0] out2_r;
    logic signed [W-1:0] out3_r;

    function automatic logic schmitt_next(input logic state, input logic signed [W-1:0] x);
        if (!state) begin
            return (x > HI_TH);
        end else begin
            return !(x < LO_TH);
        end
    endfunction

    // Schmitt triggers, edge detection and next routing selection
    always_comb begin
        clk_st_next_s  = schmitt_next(clk_st_r, bus.sample_in0);
        trig_st_next_s = schmitt_next(trig_st_r, bus.sample_in2);
        clk_edge_s     = clk_st_next_s & ~clk_st_r;
        trig_edge_s    = trig_st_next_s & ~trig_st_r;
        reverse_s      = (bus.sample_in3 > HI_TH);

        case (sel_r)
            SEL_OUT1: step_s = reverse_s ? SEL_OUT3 : SEL_OUT2;
            SEL_OUT2: step_s = reverse_s ? SEL_OUT1 : SEL_OUT3;
            SEL_OUT3: step_s = reverse_s ? SEL_OUT2 : SEL_OUT1;
            default:  step_s = SEL_OUT1;
        endcase

        // the reset trigger outranks a coincident step
        if (sel_r == SEL_BAD) begin
            sel_next_s = SEL_OUT1;
        end else if (trig_edge_s) begin
            sel_next_s = SEL_OUT1;
        end else if (clk_edge_s) begin
            sel_next_s = step_s;
        end else begin
            sel_next_s = sel_r;
        end
    end

    // State and output registers; outputs are written using the pre-update selection
    always_ff @(posedge sample_clk) begin
        if (rst) begin
            sel_r     <= SEL_OUT1;
            clk_st_r  <= 1'b0;
            trig_st_r <= 1'b0;
            out0_r    <= ZERO;
            out1_r    <= ZERO;
            out2_r    <= ZERO;
            out3_r    <= ZERO;
        end else begin
            sel_r     <= sel_next_s;
            clk_st_r  <= clk_st_next_s;
            trig_st_r <= trig_st_next_s;
            out0_r    <= clk_st_next_s ? GATE_HI : ZERO;
`ifdef SEQDEMUX_ZERO_UNSELECTED_EN
            out1_r    <= (sel_r == SEL_OUT1) ? bus.sample_in1 : ZERO;
            out2_r    <= (sel_r == SEL_OUT2) ? bus.sample_in1 : ZERO;
            out3_r    <= (sel_r == SEL_OUT3) ? bus.sample_in1 : ZERO;
`else
            if (sel_r == SEL_OUT1) begin
                out1_r <= bus.sample_in1;
            end else begin
                out1_r <= out1_r;
            end
            if (sel_r == SEL_OUT2) begin
                out2_r <= bus.sample_in1;
            end else begin
                out2_r <= out2_r;
            end
            if (sel_r == SEL_OUT3) begin
                out3_r <= bus.sample_in1;
            end else begin
                out3_r <= out3_r;
            end
`endif
        end
    end

    assign bus.sample_out0 = out0_r;
    assign bus.sample_out1 = out1_r;
    assign bus.sample_out2 = out2_r;
    assign bus.sample_out3 = out3_r;
endmodule

// File: tb/tb_seqdemux.sv
// Self-checking bench for seqdemux: per-cycle comparison against a behavioural model
// plus directed literal expectations.
module tb_seqdemux;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seqdemux_if #(.W(16)) bus ();

    seqdemux #(.W(16), .FP_OFFSET(2)) dut (
        .sample_clk (clk),
        .rst        (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int m_sel;
    bit m_s0, m_s2, m_valid;
    int m_out[4];
    int m_edges;
    int x0, x1, x2, x3;
    bit n0, n2, e0, e2;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int a0, input int a1, input int a2, input int a3);
        bus.sample_in0 = 16'(a0);
        bus.sample_in1 = 16'(a1);
        bus.sample_in2 = 16'(a2);
        bus.sample_in3 = 16'(a3);
        @(negedge clk);
    endtask

    // Model: hysteresis comparators, modular step of a 3-way pointer, track/hold array
    initial begin
        m_valid = 1'b0;
        m_edges = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_sel = 0;
                m_s0  = 1'b0;
                m_s2  = 1'b0;
                for (int k = 0; k < 4; k++) m_out[k] = 0;
            end else begin
                x0 = bus.sample_in0;
                x1 = bus.sample_in1;
                x2 = bus.sample_in2;
                x3 = bus.sample_in3;
                n0 = m_s0 ? (x0 >= 2000) : (x0 > 8000);
                n2 = m_s2 ? (x2 >= 2000) : (x2 > 8000);
                e0 = n0 && !m_s0;
                e2 = n2 && !m_s2;
`ifdef SEQDEMUX_ZERO_UNSELECTED_EN
                for (int k = 1; k < 4; k++) m_out[k] = 0;
`endif
                m_out[m_sel + 1] = x1;
                m_out[0] = n0 ? 20000 : 0;
                if (e2) m_sel = 0;
                else if (e0) m_sel = (x3 > 8000) ? (m_sel + 2) % 3 : (m_sel + 1) % 3;
                if (e0) m_edges++;
                m_s0 = n0;
                m_s2 = n2;
            end
            m_valid = 1'b1;
        end
    end

    // Compare every output against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_out0", int'(bus.sample_out0), m_out[0]);
                check("model_out1", int'(bus.sample_out1), m_out[1]);
                check("model_out2", int'(bus.sample_out2), m_out[2]);
                check("model_out3", int'(bus.sample_out3), m_out[3]);
            end
        end
    end

    int v, ve, eb;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.sample_in0 = 16'sd0;
        bus.sample_in1 = 16'sd0;
        bus.sample_in2 = 16'sd0;
        bus.sample_in3 = 16'sd0;

        // Reset with in1 = 1234
        cyc(0, 1234, 0, 0);
        cyc(0, 1234, 0, 0);
        check("rst_out0", int'(bus.sample_out0), 0);
        check("rst_out1", int'(bus.sample_out1), 0);
        check("rst_out2", int'(bus.sample_out2), 0);
        check("rst_out3", int'(bus.sample_out3), 0);
        rst = 1'b0;
        cyc(0, 1234, 0, 0);
        check("rel_out1", int'(bus.sample_out1), 1234);
        check("rel_out2", int'(bus.sample_out2), 0);
        check("rel_out3", int'(bus.sample_out3), 0);

        // Forward stepping with ramping in1: sel 1, 2, 0
        v = 1;
        for (int p = 0; p < 3; p++) begin
            cyc(0, v, 0, 0); v++;
            cyc(0, v, 0, 0); v++;
            ve = v;
            cyc(12000, v, 0, 0); v++;
            if (p == 0) check("gate_hi", int'(bus.sample_out0), 20000);
            cyc(12000, v, 0, 0); v++;
            cyc(0, v, 0, 0); v++;
            cyc(0, v, 0, 0); v++;
            cyc(0, 100 * (p + 1), 0, 0);
            case (p)
                0: check("fwd_out2", int'(bus.sample_out2), 100);
                1: check("fwd_out3", int'(bus.sample_out3), 200);
                default: check("fwd_out1", int'(bus.sample_out1), 300);
            endcase
            if (p == 0) begin
`ifdef SEQDEMUX_ZERO_UNSELECTED_EN
                check("freeze_out1", int'(bus.sample_out1), 0);
`else
                check("freeze_out1", int'(bus.sample_out1), ve);
`endif
            end
        end

        // Hysteresis: two edges from the bouncing sequence
        eb = m_edges;
        cyc(0, 5, 0, 0);
        cyc(9000, 5, 0, 0);
        cyc(4000, 5, 0, 0);
        cyc(9000, 5, 0, 0);
        cyc(1000, 5, 0, 0);
        cyc(9000, 5, 0, 0);
        cyc(0, 5, 0, 0);
        check("hyst_edges", m_edges - eb, 2);
        cyc(0, 4242, 0, 0);
        check("hyst_out3", int'(bus.sample_out3), 4242);

        // Slow ramp: one edge
        eb = m_edges;
        for (int i = 1; i <= 100; i++) cyc(i * 120, 6, 0, 0);
        cyc(0, 6, 0, 0);
        check("ramp_edges", m_edges - eb, 1);
        cyc(0, 4343, 0, 0);
        check("ramp_out1", int'(bus.sample_out1), 4343);

        // Reverse stepping: sel 2 then 1
        cyc(12000, 7, 0, 12000);
        cyc(0, 7, 0, 12000);
        cyc(0, 501, 0, 12000);
        check("rev_out3", int'(bus.sample_out3), 501);
        cyc(12000, 7, 0, 12000);
        cyc(0, 7, 0, 12000);
        cyc(0, 502, 0, 12000);
        check("rev_out2", int'(bus.sample_out2), 502);

        // Reset trigger edge returns to output 1
        cyc(0, 8, 12000, 12000);
        cyc(0, 8, 0, 12000);
        cyc(0, 503, 0, 12000);
        check("trig_out1", int'(bus.sample_out1), 503);

        // Coincident edges: trigger wins
        cyc(12000, 9, 0, 12000);
        cyc(0, 9, 0, 12000);
        cyc(0, 504, 0, 12000);
        check("pre_coin_out3", int'(bus.sample_out3), 504);
        cyc(12000, 9, 12000, 12000);
        cyc(0, 9, 0, 12000);
        cyc(0, 505, 0, 12000);
        check("coin_out1", int'(bus.sample_out1), 505);

        // Bit-exact negative full scale
        cyc(0, -32768, 0, 0);
        check("negfs_out1", int'(bus.sample_out1), -32768);

        // Gate latency
        cyc(12000, 10, 0, 0);
        check("gate_on", int'(bus.sample_out0), 20000);
        cyc(0, 10, 0, 0);
        check("gate_off", int'(bus.sample_out0), 0);

        // Mid-sequence reset with in0 held high: edge on first cycle after release
        rst = 1'b1;
        cyc(12000, 11, 0, 0);
        check("mid_rst_out2", int'(bus.sample_out2), 0);
        rst = 1'b0;
        cyc(12000, 600, 0, 0);
        check("post_rst_out1", int'(bus.sample_out1), 600);
        check("post_rst_gate", int'(bus.sample_out0), 20000);
        cyc(12000, 601, 0, 0);
        check("post_rst_out2", int'(bus.sample_out2), 601);
        cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seqdemux.md
SEQDEMUX -- requirements
Module: seqdemux

Interface
REQ-001 Parameter W, default 16: sample width in bits; all sample ports are signed W-bit.
REQ-002 Parameter FP_OFFSET, default 2: fractional bits; a sample equals millivolts shifted left by FP_OFFSET.
REQ-003 sample_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sample_in0  input  W  step clock CV.
REQ-006 sample_in1  input  W  signal to be distributed.
REQ-007 sample_in2  input  W  reset trigger CV; returns routing to output 1.
REQ-008 sample_in3  input  W  direction CV; high selects reverse stepping.
REQ-009 sample_out0  output  W  registered gate: 5000 mV (20000 counts) while step-clock Schmitt state is high, else 0.
REQ-010 sample_out1..sample_out3  output  W each  distributed outputs, registered.

Function
REQ-011 Thresholds: HI = 2000 mV (8000 counts); LO = 500 mV (2000 counts); comparisons signed, strict (> HI, < LO).
REQ-012 Independent Schmitt state for in0 and in2: set when input > HI while clear; cleared when input < LO while set; otherwise held.
REQ-013 Rising edge = the cycle in which a Schmitt state goes clear to set; exactly one edge per crossing, none while held between LO and HI.
REQ-014 Direction is high when sample_in3 > HI; it is sampled in the edge cycle, with no hysteresis.
REQ-015 State sel in {0,1,2} (output 1,2,3); encoding 3 unreachable; if ever reached, next cycle sel = 0.
REQ-016 in0 rising edge, forward: 0->1->2->0; reverse: 0->2->1->0.
REQ-017 in2 rising edge: sel <= 0 irrespective of its current value.
REQ-018 Simultaneous in0 and in2 edges in the same cycle: in2 wins, sel <= 0, no step.
REQ-019 Every cycle, the output indexed by current sel (pre-update value) is loaded with sample_in1 (1-cycle latency).
REQ-020 Non-selected outputs hold their last value (track-and-hold), unless modified by REQ-027.
REQ-021 A sel change in cycle k takes effect for the output write in cycle k+1; the previously selected output retains the value written in cycle k.
REQ-022 sample_out0 is updated every cycle from the post-update in0 Schmitt state (1-cycle latency from the crossing).
REQ-023 No arithmetic on sample_in1; values pass bit-exact, including negative full scale.

Reset
REQ-024 While rst is high at a clock edge: sel = 0, both Schmitt states clear, sample_out0..3 = 0.
REQ-025 Reset mid-sequence discards the current routing; an input already above HI at rst release produces an edge on the first cycle after release.
REQ-026 Normal operation resumes on the first edge with rst low.

Configuration
REQ-027 Macro SEQDEMUX_ZERO_UNSELECTED_EN.
- Defined: non-selected outputs are driven to 0 every cycle (gated demultiplexer).
- Undefined: REQ-020 hold behaviour applies.
- sample_out0, sel logic and latency are identical in both builds.

Verification
REQ-028 Reset: rst high 2 cycles with in1 = 1234 -> all outputs 0. Release -> out1 = 1234 one cycle later; out2 = out3 = 0.
REQ-029 Forward stepping: in1 ramps +1 per cycle, in3 = 0, in0 pulses 0 -> 12000 -> 0 three times -> sel goes 1,2,0. Each edge makes the previous output freeze at its last value, and the next output starts tracking one cycle later.
REQ-030 Hysteresis: in0 sequence 0, 9000, 4000, 9000, 1000, 9000 -> exactly two edges. A slow ramp 0->12000 in 100 steps -> exactly one edge.
REQ-031 Reverse and reset: in3 = 12000, two in0 edges -> sel 2 then 1. An in2 edge -> sel 0. Coincident in0 and in2 edges -> sel 0.
REQ-032 Gate and bit-exactness: in0 = 12000 -> out0 = 20000 after 1 cycle. in1 = -32768 -> selected output = -32768.
REQ-033 Rebuild with SEQDEMUX_ZERO_UNSELECTED_EN and repeat REQ-029 -> non-selected outputs read 0; selected-output values and timing are unchanged.
